// File: rtl/neuron_act_collector_if.sv
// Handshake bundle for the activation collector: scalar result in, packed
// activation vector out, plus the per-vector saturation flag.
interface neuron_act_collector_if #(
    parameter int N     = 20,
    parameter int IN_W  = 13,
    parameter int ACT_W = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*ACT_W-1:0]   out_act;
    logic                 sat_seen;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_act, sat_seen
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_act, sat_seen
    );
endinterface

// File: rtl/neuron_act_collector.sv
// Requantises signed neuron results to ACT_W-bit activations (optional ReLU)
// and gathers N of them into a vector handed off under valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting results, writing entry[idx]; out_valid low
// FULL    | vector complete and held stable until out_ready; in_ready low
module neuron_act_collector #(
    parameter int N       = 20,
    parameter int IN_W    = 13,
    parameter int ACT_W   = 9,
    parameter int SHIFT   = 2,
    parameter int RELU_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    neuron_act_collector_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [IN_W-1:0] ACT_MAX = IN_W'(2**(ACT_W-1) - 1);
    localparam logic signed [IN_W-1:0] ACT_MIN = IN_W'(-(2**(ACT_W-1)));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 sat_q, sat_d;
    logic [ACT_W-1:0]     act_q [N];
    logic [N*ACT_W-1:0]   act_flat;

    logic signed [IN_W-1:0] shifted;
    logic [ACT_W-1:0]       q_val;
    logic                   q_sat;
    logic                   accept;
    logic                   handshake;

    // Arithmetic shift floors toward -inf; no rounding term is added.
    assign shifted = $signed(bus.in_data) >>> SHIFT;

    always_comb begin
        q_val = shifted[ACT_W-1:0];
        q_sat = 1'b0;
        if ((RELU_EN != 0) && (shifted < 0)) begin
            q_val = '0;
        end else if (shifted > ACT_MAX) begin
            q_val = ACT_MAX[ACT_W-1:0];
            q_sat = 1'b1;
        end else if (shifted < ACT_MIN) begin
            q_val = ACT_MIN[ACT_W-1:0];
            q_sat = 1'b1;
        end
    end

    // in_ready is gated by rst so nothing is taken while the block is held.
    assign bus.in_ready  = (state_q == COLLECT) && !rst;
    assign bus.out_valid = (state_q == FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign handshake     = (state_q == FULL) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (q_sat) sat_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (handshake) begin
                    state_d = COLLECT;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            for (int k = 0; k < N; k++) act_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            if (accept) act_q[idx_q] <= q_val;
        end
    end

    always_comb begin
        act_flat = '0;
        for (int k = 0; k < N; k++) act_flat[k*ACT_W +: ACT_W] = act_q[k];
    end

    assign bus.out_act  = act_flat;
    assign bus.sat_seen = sat_q;
endmodule
